// File: rtl/soc_axi_regs_if.sv
// AXI4-Lite bus bundle for the soc_axi_regs register file.
// The master modport is the host side, the slave modport is the register file.
interface soc_axi_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/soc_axi_regs.sv
// AXI4-Lite register file: five host-writable control words, three read-only status words.
// Optional macro SOC_ROM_AUTOINC_EN: writes to register 3 also bump the ROM address in register 2[6:1].
module soc_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    soc_axi_regs_if.slave                 s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg3,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg4,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg5,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg6,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg7
);
    localparam int NUM_CTRL  = 5;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    logic awready_reg, wready_reg, bvalid_reg;
    logic arready_reg, rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_next;
    logic [NUM_CTRL-1:0][C_S_AXI_DATA_WIDTH-1:0] ctrl_reg;
    logic [NUM_CTRL-1:0][C_S_AXI_DATA_WIDTH-1:0] ctrl_next;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    logic [2:0] wr_sel, rd_sel;
    logic aw_take, wr_fire, ar_take, rd_fire;
    logic unused_in;

    assign awaddr = s_axi.S_AXI_AWADDR;
    assign araddr = s_axi.S_AXI_ARADDR;
    assign wr_sel = awaddr[4:2];
    assign rd_sel = araddr[4:2];
    assign unused_in = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

    // READY is registered: it rises the cycle after AW and W are both seen, so the
    // cycle where it is high is the handshake and the commit happens on its closing edge.
    assign aw_take = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_reg & ~awready_reg;
    assign wr_fire = awready_reg & s_axi.S_AXI_AWVALID & wready_reg & s_axi.S_AXI_WVALID;
    assign ar_take = s_axi.S_AXI_ARVALID & ~rvalid_reg & ~arready_reg;
    assign rd_fire = arready_reg & s_axi.S_AXI_ARVALID;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            awready_reg <= aw_take;
            wready_reg  <= aw_take;
            if (wr_fire)
                bvalid_reg <= 1'b1;
            else if (s_axi.S_AXI_BREADY)
                bvalid_reg <= 1'b0;
        end
    end

    // Per-lane merge of write data into the addressed control word.
    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        for (genvar gb = 0; gb < NUM_LANES; gb++) begin : g_lane
            assign ctrl_next[gi][8*gb +: 8] =
                (wr_fire && (wr_sel == 3'(gi)) && s_axi.S_AXI_WSTRB[gb])
                    ? s_axi.S_AXI_WDATA[8*gb +: 8]
                    : ctrl_reg[gi][8*gb +: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_reg <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
`ifdef SOC_ROM_AUTOINC_EN
            // Register 2 is never written in the same cycle as register 3, so this
            // override of the ROM address field cannot clash with a host write.
            if (wr_fire && (wr_sel == 3'd3) && (|s_axi.S_AXI_WSTRB))
                ctrl_reg[2][6:1] <= ctrl_reg[2][6:1] + 6'd1;
`endif
        end
    end

    always_comb begin
        rdata_next = '0;
        case (rd_sel)
            3'd0:    rdata_next = ctrl_reg[0];
            3'd1:    rdata_next = ctrl_reg[1];
            3'd2:    rdata_next = ctrl_reg[2];
            3'd3:    rdata_next = ctrl_reg[3];
            3'd4:    rdata_next = ctrl_reg[4];
            3'd5:    rdata_next = write_to_slv_reg5;
            3'd6:    rdata_next = write_to_slv_reg6;
            default: rdata_next = write_to_slv_reg7;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            arready_reg <= ar_take;
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rdata_next;
            end else if (s_axi.S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_reg;
    assign s_axi.S_AXI_WREADY  = wready_reg;
    assign s_axi.S_AXI_BVALID  = bvalid_reg;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready_reg;
    assign s_axi.S_AXI_RVALID  = rvalid_reg;
    assign s_axi.S_AXI_RDATA   = rdata_reg;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign read_from_slv_reg0 = ctrl_reg[0];
    assign read_from_slv_reg1 = ctrl_reg[1];
    assign read_from_slv_reg2 = ctrl_reg[2];
    assign read_from_slv_reg3 = ctrl_reg[3];
    assign read_from_slv_reg4 = ctrl_reg[4];
endmodule
